// File: rtl/grid_write_arbiter.sv
// -----------------------------------------------------------------------------
// grid_write_arbiter
//
// Shares the single grid_register write port between the snake movement logic
// and the food spawner, and runs a full-grid clear sweep on request.
// Arbitration is fixed priority (snake first) with a starvation guard that
// hands priority to food once it has lost STARVE_LIM times in a row. Requester
// grants can be confined to vertical blanking so a displayed frame never tears.
//
// Ports:
//   clk, rst          65 MHz clock, synchronous active-high reset
//   vblnk             vertical blanking flag (gates requester grants)
//   clear_start       single-cycle pulse that starts a full-grid clear
//   snake_req/addr/data, food_req/addr/data   requester write words
//   snake_gnt, food_gnt                       one-cycle registered grants
//   wr_en, wr_addr, wr_data                   grid_register write port
//   clear_busy, clear_done                    sweep status / completion pulse
//   dbg_state, dbg_starve_cnt                 FSM state and starvation count
//
// Handshake: a requester holds req/addr/data stable until it sees its gnt.
// A word sampled eligible at cycle t is granted and written at t+1 (gnt and
// wr_en high together for exactly one cycle). The requester may drop req at
// any time before the grant with no side effects. Because a requester whose
// gnt is currently high is masked, a held word is never written twice.
// -----------------------------------------------------------------------------
module grid_write_arbiter #(
    parameter int                ADDR_W         = 10,
    parameter int                DATA_W         = 4,
    parameter int                GRID_CELLS     = 768,
    parameter logic [DATA_W-1:0] CLEAR_DATA     = 4'h0,
    parameter int                STARVE_LIM     = 4,
    parameter int                SYNC_TO_VBLANK = 1,
    localparam int               STARVE_W       = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vblnk,
    input  logic                clear_start,
    input  logic                snake_req,
    input  logic [ADDR_W-1:0]   snake_addr,
    input  logic [DATA_W-1:0]   snake_data,
    input  logic                food_req,
    input  logic [ADDR_W-1:0]   food_addr,
    input  logic [DATA_W-1:0]   food_data,
    output logic                snake_gnt,
    output logic                food_gnt,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic                clear_busy,
    output logic                clear_done,
    output logic                dbg_state,
    output logic [STARVE_W-1:0] dbg_starve_cnt
);

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(GRID_CELLS - 1);
    localparam logic [STARVE_W-1:0] LIM       = STARVE_W'(STARVE_LIM);

    state_t              state;
    state_t              state_next;

    logic [ADDR_W-1:0]   sweep_addr;   // address written in the current CLEAR cycle
    logic [ADDR_W-1:0]   sweep_d;
    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_d;

    logic                snake_gnt_d;
    logic                food_gnt_d;
    logic                wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_d;
    logic [DATA_W-1:0]   wr_data_d;
    logic                clear_busy_d;
    logic                clear_done_d;

    logic                vb_ok;
    logic                snake_elig;
    logic                food_elig;
    logic                food_win;
    logic                snake_win;

    // Eligibility: the registered gnt doubles as a mask so the word that is
    // being written this cycle cannot be re-granted from the still-held req.
    assign vb_ok      = (SYNC_TO_VBLANK == 0) || vblnk;
    assign snake_elig = snake_req && !snake_gnt && vb_ok;
    assign food_elig  = food_req  && !food_gnt  && vb_ok;
    assign food_win   = food_elig && (!snake_elig || (starve_cnt >= LIM));
    assign snake_win  = snake_elig && !food_win;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ARB:     if (clear_start) state_next = CLEAR;
            CLEAR:   if (sweep_addr == LAST_ADDR) state_next = ARB;
            default: state_next = ARB;
        endcase
    end

    // Output logic: next values of the registered outputs and counters.
    // wr_addr/wr_data are driven to zero on cycles without a write.
    always_comb begin
        snake_gnt_d  = 1'b0;
        food_gnt_d   = 1'b0;
        wr_en_d      = 1'b0;
        wr_addr_d    = '0;
        wr_data_d    = '0;
        clear_busy_d = 1'b0;
        clear_done_d = 1'b0;
        sweep_d      = sweep_addr;
        // A withdrawn food request forgets any accumulated losses.
        starve_d     = food_req ? starve_cnt : '0;

        unique case (state)
            ARB: begin
                if (clear_start) begin
                    // The clear takes the slot; pending requests stay pending.
                    clear_busy_d = 1'b1;
                    wr_en_d      = 1'b1;
                    wr_addr_d    = '0;
                    wr_data_d    = CLEAR_DATA;
                    sweep_d      = '0;
                end else if (food_win) begin
                    food_gnt_d = 1'b1;
                    wr_en_d    = 1'b1;
                    wr_addr_d  = food_addr;
                    wr_data_d  = food_data;
                    starve_d   = '0;
                end else if (snake_win) begin
                    snake_gnt_d = 1'b1;
                    wr_en_d     = 1'b1;
                    wr_addr_d   = snake_addr;
                    wr_data_d   = snake_data;
                    if (food_elig && (starve_cnt < LIM)) begin
                        starve_d = starve_cnt + STARVE_W'(1);
                    end
                end
            end
            CLEAR: begin
                if (sweep_addr == LAST_ADDR) begin
                    clear_done_d = 1'b1;
                    sweep_d      = '0;
                end else begin
                    sweep_d      = sweep_addr + ADDR_W'(1);
                    clear_busy_d = 1'b1;
                    wr_en_d      = 1'b1;
                    wr_addr_d    = sweep_addr + ADDR_W'(1);
                    wr_data_d    = CLEAR_DATA;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            snake_gnt  <= 1'b0;
            food_gnt   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
            sweep_addr <= '0;
            starve_cnt <= '0;
        end else begin
            snake_gnt  <= snake_gnt_d;
            food_gnt   <= food_gnt_d;
            wr_en      <= wr_en_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            clear_busy <= clear_busy_d;
            clear_done <= clear_done_d;
            sweep_addr <= sweep_d;
            starve_cnt <= starve_d;
        end
    end

    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_grid_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_grid_write_arbiter
//
// Directed scenarios followed by a randomized run. A reference model of the
// arbiter, expressed as "clear writes remaining", "last grants" and a loss
// count, predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_grid_write_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 4;
    localparam int GRID   = 768;
    localparam int LIM    = 4;
    localparam int CLR    = 0;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              vblnk = 1'b0;
    logic              clear_start = 1'b0;
    logic              snake_req = 1'b0;
    logic [ADDR_W-1:0] snake_addr = '0;
    logic [DATA_W-1:0] snake_data = '0;
    logic              food_req = 1'b0;
    logic [ADDR_W-1:0] food_addr = '0;
    logic [DATA_W-1:0] food_data = '0;
    logic              snake_gnt, food_gnt, wr_en, clear_busy, clear_done, dbg_state;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [2:0]        dbg_starve_cnt;

    grid_write_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .GRID_CELLS(GRID), .CLEAR_DATA(4'h0),
        .STARVE_LIM(LIM), .SYNC_TO_VBLANK(1)
    ) dut (
        .clk(clk), .rst(rst), .vblnk(vblnk), .clear_start(clear_start),
        .snake_req(snake_req), .snake_addr(snake_addr), .snake_data(snake_data),
        .food_req(food_req), .food_addr(food_addr), .food_data(food_data),
        .snake_gnt(snake_gnt), .food_gnt(food_gnt), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .clear_busy(clear_busy),
        .clear_done(clear_done), .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
    );

    // scoreboard counters
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model
    int clear_left = 0;   // clear writes still to be issued, incl. the current one
    bit m_sg, m_fg, m_wen, m_busy, m_done;
    int m_waddr, m_wdata, m_starve;

    task automatic model_edge();
        bit se, fe, food_first, prev_sg, prev_fg;
        prev_sg = m_sg;
        prev_fg = m_fg;
        m_sg = 0; m_fg = 0; m_wen = 0; m_waddr = 0; m_wdata = 0; m_busy = 0; m_done = 0;
        if (rst) begin
            clear_left = 0;
            m_starve   = 0;
            return;
        end
        if (clear_left > 0) begin
            if (clear_left == 1) begin
                clear_left = 0;
                m_done     = 1;
            end else begin
                clear_left--;
                m_wen = 1; m_busy = 1; m_waddr = GRID - clear_left; m_wdata = CLR;
            end
            if (!food_req) m_starve = 0;
        end else if (clear_start) begin
            clear_left = GRID;
            m_wen = 1; m_busy = 1; m_waddr = 0; m_wdata = CLR;
            if (!food_req) m_starve = 0;
        end else begin
            se = snake_req && !prev_sg && vblnk;
            fe = food_req  && !prev_fg && vblnk;
            food_first = fe && (!se || m_starve >= LIM);
            if (food_first) begin
                m_fg = 1; m_wen = 1; m_waddr = int'(food_addr); m_wdata = int'(food_data);
                m_starve = 0;
            end else if (se) begin
                m_sg = 1; m_wen = 1; m_waddr = int'(snake_addr); m_wdata = int'(snake_data);
                if (fe && m_starve < LIM) m_starve++;
                else if (!food_req) m_starve = 0;
            end else if (!food_req) begin
                m_starve = 0;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("snake_gnt",  32'(snake_gnt),      32'(m_sg));
        check_eq("food_gnt",   32'(food_gnt),       32'(m_fg));
        check_eq("wr_en",      32'(wr_en),          32'(m_wen));
        check_eq("wr_addr",    32'(wr_addr),        32'(m_waddr));
        check_eq("wr_data",    32'(wr_data),        32'(m_wdata));
        check_eq("clear_busy", 32'(clear_busy),     32'(m_busy));
        check_eq("clear_done", 32'(clear_done),     32'(m_done));
        check_eq("state",      32'(dbg_state),      32'(clear_left > 0));
        check_eq("starve_cnt", 32'(dbg_starve_cnt), 32'(m_starve));
    endtask

    // one clock: model advances on the edge, outputs checked 1 time unit later
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // random driver: requesters obey the hold-until-grant contract
    task automatic drive_random();
        if (snake_req && m_sg) begin
            snake_req = ($urandom_range(0, 1) == 1);
            snake_addr = ADDR_W'($urandom_range(0, 1023));
            snake_data = DATA_W'($urandom_range(0, 15));
        end else if (snake_req) begin
            if ($urandom_range(0, 29) == 0) snake_req = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
            snake_req = 1'b1;
            snake_addr = ADDR_W'($urandom_range(0, 1023));
            snake_data = DATA_W'($urandom_range(0, 15));
        end
        if (food_req && m_fg) begin
            food_req = ($urandom_range(0, 3) == 0);
            food_addr = ADDR_W'($urandom_range(0, 1023));
            food_data = DATA_W'($urandom_range(0, 15));
        end else if (food_req) begin
            if ($urandom_range(0, 29) == 0) food_req = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
            food_req = 1'b1;
            food_addr = ADDR_W'($urandom_range(0, 1023));
            food_data = DATA_W'($urandom_range(0, 15));
        end
        if ($urandom_range(0, 15) == 0) vblnk = ~vblnk;
        clear_start = ($urandom_range(0, 399) == 0);
        rst = ($urandom_range(0, 2499) == 0);
    endtask

    int bad;

    initial begin
        // reset and idle
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        vblnk = 1'b1;
        step();
        check_eq("idle_wr_en", 32'(wr_en), 32'd0);
        check_eq("idle_busy",  32'(clear_busy), 32'd0);

        // single snake write, held req is not granted twice
        snake_req = 1'b1; snake_addr = 10'h12A; snake_data = 4'h3;
        step();
        check_eq("s1_gnt",  32'(snake_gnt), 32'd1);
        check_eq("s1_addr", 32'(wr_addr), 32'h12A);
        check_eq("s1_data", 32'(wr_data), 32'h3);
        step();
        check_eq("s1_no_regrant", 32'(snake_gnt), 32'd0);
        check_eq("s1_no_write",   32'(wr_en), 32'd0);
        snake_req = 1'b0;
        step();

        // food held off outside vblank, granted right after vblank rises
        vblnk = 1'b0; food_req = 1'b1; food_addr = 10'h2F0; food_data = 4'h9;
        bad = 0;
        repeat (50) begin
            step();
            if (food_gnt) bad++;
        end
        check_eq("vblank_hold", 32'(bad), 32'd0);
        vblnk = 1'b1;
        step();
        check_eq("vblank_gnt",  32'(food_gnt), 32'd1);
        check_eq("vblank_addr", 32'(wr_addr), 32'h2F0);
        food_req = 1'b0;
        step();

        // full clear with snake request pending
        snake_req = 1'b1; snake_addr = 10'h055; snake_data = 4'h7; clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        check_eq("clr_first_addr", 32'(wr_addr), 32'd0);
        check_eq("clr_first_busy", 32'(clear_busy), 32'd1);
        check_eq("clr_no_gnt",     32'(snake_gnt), 32'd0);
        bad = 0;
        for (int i = 1; i < GRID; i++) begin
            step();
            if (wr_addr != ADDR_W'(i) || !wr_en || wr_data != 4'h0 || !clear_busy || snake_gnt) bad++;
        end
        check_eq("sweep_seq", 32'(bad), 32'd0);
        step();
        check_eq("clr_done",      32'(clear_done), 32'd1);
        check_eq("clr_busy_low",  32'(clear_busy), 32'd0);
        check_eq("clr_wr_en_low", 32'(wr_en), 32'd0);
        step();
        check_eq("post_clr_gnt",  32'(snake_gnt), 32'd1);
        check_eq("post_clr_addr", 32'(wr_addr), 32'h055);
        snake_req = 1'b0;
        step();

        // reset in the middle of a sweep, then restart
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        for (int i = 1; i <= 300; i++) step();
        check_eq("mid_addr", 32'(wr_addr), 32'd300);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rst_wr_en", 32'(wr_en), 32'd0);
        check_eq("rst_busy",  32'(clear_busy), 32'd0);
        check_eq("rst_done",  32'(clear_done), 32'd0);
        step();
        check_eq("rst_no_done", 32'(clear_done), 32'd0);
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        check_eq("restart_addr", 32'(wr_addr), 32'd0);
        check_eq("restart_busy", 32'(clear_busy), 32'd1);
        repeat (GRID + 1) step();

        // food loses once, then withdraws: count drops back to zero
        snake_req = 1'b1; snake_addr = 10'h011; snake_data = 4'h1;
        food_req  = 1'b1; food_addr  = 10'h022; food_data  = 4'h2;
        step();
        check_eq("loss_snake_gnt", 32'(snake_gnt), 32'd1);
        check_eq("loss_count",     32'(dbg_starve_cnt), 32'd1);
        snake_req = 1'b0; food_req = 1'b0;
        step();
        check_eq("withdraw_no_gnt", 32'(food_gnt), 32'd0);
        check_eq("withdraw_count",  32'(dbg_starve_cnt), 32'd0);

        // randomized traffic
        repeat (6000) begin
            drive_random();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
